// File: rtl/seg_display_arbiter_if.sv
// Display-sharing bus: three page sources on one side, the
// seven-segment driver word and the grant/done handshake on the other.
interface seg_display_arbiter_if;
    logic [2:0]  req;
    logic [31:0] page0;
    logic [31:0] page1;
    logic [31:0] page2;
    logic [2:0]  grant;
    logic [2:0]  done;
    logic [31:0] disp_word;
    logic        blank;

    modport master (
        output req, page0, page1, page2,
        input  grant, done, disp_word, blank
    );

    modport slave (
        input  req, page0, page1, page2,
        output grant, done, disp_word, blank
    );
endinterface

// File: rtl/seg_display_arbiter.sv
// Arbitrates the 8-digit display between an alarm page (source 0,
// preemptive) and two round-robin pages (sources 1/2) with a minimum
// dwell per grant.
// Ports: clk, reset (async, active high), bus (slave: req, page0..2 in;
// grant, done, disp_word, blank out, all registered).
module seg_display_arbiter #(
    parameter int DWELL_TICKS = 100_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    seg_display_arbiter_if.slave  bus
);

    typedef enum logic {IDLE, SHOW} state_t;

    localparam int CW = $clog2(DWELL_TICKS);
    localparam logic [CW-1:0] LAST = CW'(DWELL_TICKS - 1);

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        rr_q, rr_d;
    logic [2:0]  grant_q, grant_d;
    logic [2:0]  done_q, done_d;
    logic [31:0] disp_word_q, disp_word_d;
    logic        blank_q, blank_d;

    // rr = 0 prefers source 1, rr = 1 prefers source 2.
    function automatic logic [2:0] pick(input logic [2:0] r,
                                        input logic       rr);
        logic [2:0] g;
        g = 3'b000;
        if (r[0])
            g = 3'b001;
        else if (r[1] && r[2])
            g = rr ? 3'b100 : 3'b010;
        else if (r[1])
            g = 3'b010;
        else if (r[2])
            g = 3'b100;
        return g;
    endfunction

    always_comb begin
        rr_d    = rr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                grant_d = pick(bus.req, rr_q);
                cnt_d   = '0;
            end
            SHOW: begin
                if (cnt_q == LAST) begin
                    // Completed dwell: hand the RR preference to the
                    // other source before choosing the next owner.
                    if (grant_q[1])
                        rr_d = 1'b1;
                    else if (grant_q[2])
                        rr_d = 1'b0;
                    grant_d = pick(bus.req, rr_d);
                    cnt_d   = '0;
                end else if (bus.req[0] && !grant_q[0]) begin
                    // Preempted source is served first afterwards.
                    rr_d    = grant_q[2];
                    grant_d = 3'b001;
                    cnt_d   = '0;
                end else if ((bus.req & grant_q) == 3'b000) begin
                    grant_d = pick(bus.req, rr_q);
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                grant_d = 3'b000;
                cnt_d   = '0;
            end
        endcase

        state_d = (grant_d == 3'b000) ? IDLE : SHOW;
        blank_d = (grant_d == 3'b000);

        // done is raised for the cycle that holds the final count.
        done_d = 3'b000;
        if (state_d == SHOW && cnt_d == LAST)
            done_d = grant_d;

        disp_word_d = 32'h0;
        unique case (1'b1)
            grant_d[0]: disp_word_d = bus.page0;
            grant_d[1]: disp_word_d = bus.page1;
            grant_d[2]: disp_word_d = bus.page2;
            default:    disp_word_d = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rr_q        <= 1'b0;
            grant_q     <= 3'b000;
            done_q      <= 3'b000;
            disp_word_q <= 32'h0;
            blank_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            disp_word_q <= disp_word_d;
            blank_q     <= blank_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
    assign bus.disp_word = disp_word_q;
    assign bus.blank     = blank_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter: one instance with an 8-cycle
// dwell, one with a 4-cycle dwell, hand-computed expectations.
module tb_seg_display_arbiter;

    logic clk;
    logic reset;

    seg_display_arbiter_if if8 ();
    seg_display_arbiter_if if4 ();

    seg_display_arbiter #(.DWELL_TICKS(8)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (if8)
    );

    seg_display_arbiter #(.DWELL_TICKS(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [2:0] eg;
        logic [2:0] ed;

        reset = 1'b1;
        if8.req = 3'b000;
        if8.page0 = 32'h0;
        if8.page1 = 32'h0;
        if8.page2 = 32'h0;
        if4.req = 3'b000;
        if4.page0 = 32'hDEAD_0000;
        if4.page1 = 32'h1111_1111;
        if4.page2 = 32'h2222_2222;
        step();
        step();
        check("rst_grant", 32'(if8.grant), 32'h0);
        check("rst_done", 32'(if8.done), 32'h0);
        check("rst_disp", if8.disp_word, 32'h0);
        check("rst_blank", 32'(if8.blank), 32'h1);
        reset = 1'b0;
        step();

        // Single requester, 8-cycle dwell
        if8.req = 3'b010;
        if8.page1 = 32'h0403_2A11;
        step();
        check("t1_grant", 32'(if8.grant), 32'h2);
        check("t1_disp", if8.disp_word, 32'h0403_2A11);
        check("t1_blank", 32'(if8.blank), 32'h0);
        check("t1_done0", 32'(if8.done), 32'h0);
        for (int k = 1; k < 16; k++) begin
            if (k == 4)
                if8.page1 = 32'h1234_5678;
            step();
            ed = (k % 8 == 7) ? 3'b010 : 3'b000;
            check($sformatf("t1_done_k%0d", k), 32'(if8.done), 32'(ed));
            check($sformatf("t1_grant_k%0d", k), 32'(if8.grant), 32'h2);
        end
        check("t1_page_upd", if8.disp_word, 32'h1234_5678);
        if8.req = 3'b000;
        step();
        check("t1_idle_grant", 32'(if8.grant), 32'h0);
        check("t1_idle_blank", 32'(if8.blank), 32'h1);
        check("t1_idle_disp", if8.disp_word, 32'h0);

        // Round-robin 1/2, 4-cycle dwell
        if4.req = 3'b110;
        step();
        for (int k = 0; k < 12; k++) begin
            if (k > 0)
                step();
            eg = ((k / 4) % 2 == 0) ? 3'b010 : 3'b100;
            ed = (k % 4 == 3) ? eg : 3'b000;
            check($sformatf("t2_grant_k%0d", k), 32'(if4.grant), 32'(eg));
            check($sformatf("t2_done_k%0d", k), 32'(if4.done), 32'(ed));
        end
        check("t2_disp", if4.disp_word, 32'h1111_1111);
        if4.req = 3'b000;
        step();
        check("t2_idle_blank", 32'(if4.blank), 32'h1);

        // Preemption of source 2 at count 2
        if4.req = 3'b100;
        step();
        check("t3_g2", 32'(if4.grant), 32'h4);
        check("t3_disp2", if4.disp_word, 32'h2222_2222);
        step();
        step();
        check("t3_g2_c2", 32'(if4.grant), 32'h4);
        if4.req = 3'b101;
        step();
        check("t3_pre_grant", 32'(if4.grant), 32'h1);
        check("t3_pre_done", 32'(if4.done), 32'h0);
        check("t3_pre_disp", if4.disp_word, 32'hDEAD_0000);
        if4.req = 3'b111;
        for (int k = 1; k < 4; k++) begin
            step();
            ed = (k == 3) ? 3'b001 : 3'b000;
            check($sformatf("t3_s0_done_k%0d", k), 32'(if4.done), 32'(ed));
            check($sformatf("t3_s0_grant_k%0d", k), 32'(if4.grant), 32'h1);
        end
        if4.req = 3'b110;
        step();
        check("t3_regrant2", 32'(if4.grant), 32'h4);
        check("t3_regrant_done", 32'(if4.done), 32'h0);

        // Early release with no other requester
        if4.req = 3'b000;
        step();
        check("t4_grant", 32'(if4.grant), 32'h0);
        check("t4_blank", 32'(if4.blank), 32'h1);
        check("t4_disp", if4.disp_word, 32'h0);
        check("t4_done", 32'(if4.done), 32'h0);

        // Asynchronous reset mid-dwell
        if4.req = 3'b100;
        step();
        check("t5_g2", 32'(if4.grant), 32'h4);
        step();
        #1 reset = 1'b1;
        #1;
        check("t5_rst_grant", 32'(if4.grant), 32'h0);
        check("t5_rst_done", 32'(if4.done), 32'h0);
        check("t5_rst_disp", if4.disp_word, 32'h0);
        check("t5_rst_blank", 32'(if4.blank), 32'h1);
        if4.req = 3'b110;
        step();
        reset = 1'b0;
        step();
        check("t5_after_grant", 32'(if4.grant), 32'h2);
        check("t5_after_disp", if4.disp_word, 32'h1111_1111);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
